writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/wb_pkg.sv | 30 +++
 rtl/writeback_stage_if.sv | 23 ++
 rtl/reg_file_32x32.sv | 42 ++++
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage and its register file.
package wb_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PAIR = 2'd3
    } wb_code_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PAIR2 = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_write_t;

    // The second half of a pair lands one register up; 31 wraps onto register 0.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [ADDR_W-1:0] dest);
        return dest + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Register-file port bundle: one write port and two combinational read ports.
interface writeback_stage_if;
    import wb_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );

endinterface

// File: rtl/reg_file_32x32.sv
// 32x32 register file: register 0 hardwired to zero, reads bypass the same-cycle write.
module reg_file_32x32
    import wb_pkg::*;
(
    input  logic              clock1,
    input  logic              reset_n,
    writeback_stage_if.slave  rf
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // NOTE: every entry carries the async reset because the whole file must read zero
    // the moment reset asserts; state is updated with <= so all flops sample together.
    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (rf.we && (rf.waddr != '0)) begin
            r_regs[rf.waddr] <= rf.wdata;
        end
    end

    always_comb begin
        rf.rdata_a = r_regs[rf.raddr_a];
        if (rf.raddr_a == '0) begin
            rf.rdata_a = '0;
        end else if (rf.we && (rf.waddr == rf.raddr_a)) begin
            rf.rdata_a = rf.wdata;
        end
    end

    always_comb begin
        rf.rdata_b = r_regs[rf.raddr_b];
        if (rf.raddr_b == '0) begin
            rf.rdata_b = '0;
        end else if (rf.we && (rf.waddr == rf.raddr_b)) begin
            rf.rdata_b = rf.wdata;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits ALU/memory results, splits pair writes over two cycles.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage
    import wb_pkg::*;
(
    input  logic              clock1,
    input  logic              reset_n,
    input  logic [1:0]        WRITEBACK_WRITEBACK,
    input  logic              MEMORY_READ_WRITEBACK,
    input  logic [ADDR_W-1:0] destination_WRITEBACK,
    input  logic [DATA_W-1:0] result_ALU1_WRITEBACK,
    input  logic [DATA_W-1:0] result_ALU2_WRITEBACK,
    input  logic [DATA_W-1:0] memory_out_WRITEBACK,
    input  logic [ADDR_W-1:0] read_address_A,
    input  logic [ADDR_W-1:0] read_address_B,
    output logic [DATA_W-1:0] read_data_A,
    output logic [DATA_W-1:0] read_data_B,
    output logic              stall_WRITEBACK,
    output logic              write_enable_out,
    output logic [ADDR_W-1:0] write_address_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic              wb_error
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [DATA_W-1:0] retired_count
`endif
);

    wb_state_e r_state;
    wb_state_e w_state_next;
    wb_write_t r_pair;
    wb_write_t w_pair_next;
    wb_write_t w_wr;
    logic      w_wr_valid;
    logic      w_stall;
    logic      w_set_error;
    logic      r_error;
    wb_code_e  w_code;

    writeback_stage_if u_rf_bus ();

    assign w_code = wb_code_e'(WRITEBACK_WRITEBACK);

    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pair  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pair  <= w_pair_next;
            r_error <= r_error | w_set_error;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        w_state_next = r_state;
        w_pair_next  = r_pair;
        w_wr         = '0;
        w_wr_valid   = 1'b0;
        w_stall      = 1'b0;
        w_set_error  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (w_code)
                    WB_ALU: begin
                        w_wr_valid = 1'b1;
                        w_wr.addr  = destination_WRITEBACK;
                        w_wr.data  = result_ALU1_WRITEBACK;
                    end
                    WB_MEM: begin
                        if (MEMORY_READ_WRITEBACK) begin
                            w_wr_valid = 1'b1;
                            w_wr.addr  = destination_WRITEBACK;
                            w_wr.data  = memory_out_WRITEBACK;
                        end else begin
                            w_set_error = 1'b1;
                        end
                    end
                    WB_PAIR: begin
                        w_stall          = 1'b1;
                        w_wr_valid       = 1'b1;
                        w_wr.addr        = destination_WRITEBACK;
                        w_wr.data        = result_ALU1_WRITEBACK;
                        w_pair_next.addr = pair_addr(destination_WRITEBACK);
                        w_pair_next.data = result_ALU2_WRITEBACK;
                        w_state_next     = ST_PAIR2;
                    end
                    default: ;
                endcase
            end
            ST_PAIR2: begin
                // Upstream inputs are ignored here; only the latched half commits.
                w_wr_valid   = 1'b1;
                w_wr         = r_pair;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Combinational outputs are gated by reset so nothing escapes while it is held.
    assign stall_WRITEBACK   = w_stall & reset_n;
    assign write_enable_out  = w_wr_valid & reset_n & (w_wr.addr != '0);
    assign write_address_out = w_wr.addr;
    assign write_data_out    = w_wr.data;
    assign wb_error          = r_error;

    assign u_rf_bus.we      = write_enable_out;
    assign u_rf_bus.waddr   = w_wr.addr;
    assign u_rf_bus.wdata   = w_wr.data;
    assign u_rf_bus.raddr_a = read_address_A;
    assign u_rf_bus.raddr_b = read_address_B;
    assign read_data_A      = u_rf_bus.rdata_a;
    assign read_data_B      = u_rf_bus.rdata_b;

    reg_file_32x32 u_reg_file (
        .clock1  (clock1),
        .reset_n (reset_n),
        .rf      (u_rf_bus)
    );

`ifdef WB_RETIRE_COUNT_EN
    logic [DATA_W-1:0] r_retired;
    logic              w_retire;

    // A pair retires once, on its second (non-stalling) half.
    assign w_retire = w_wr_valid & ~w_stall;

    always_ff @(posedge clock1 or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + DATA_W'(1);
        end
    end

    assign retired_count = r_retired;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_writeback_stage;
    import wb_pkg::*;

    logic        clock1 = 1'b0;
    logic        reset_n;
    logic [1:0]  code;
    logic        mem_rd;
    logic [4:0]  dest;
    logic [31:0] alu1;
    logic [31:0] alu2;
    logic [31:0] mem_out;
    logic        stall;
    logic        wb_error;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    writeback_stage_if obs ();

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    wb_write_t   m_pending [$];
    logic        m_error   = 1'b0;
    logic [31:0] m_retired = '0;

    writeback_stage dut (
        .clock1                (clock1),
        .reset_n               (reset_n),
        .WRITEBACK_WRITEBACK   (code),
        .MEMORY_READ_WRITEBACK (mem_rd),
        .destination_WRITEBACK (dest),
        .result_ALU1_WRITEBACK (alu1),
        .result_ALU2_WRITEBACK (alu2),
        .memory_out_WRITEBACK  (mem_out),
        .read_address_A        (obs.raddr_a),
        .read_address_B        (obs.raddr_b),
        .read_data_A           (obs.rdata_a),
        .read_data_B           (obs.rdata_b),
        .stall_WRITEBACK       (stall),
        .write_enable_out      (obs.we),
        .write_address_out     (obs.waddr),
        .write_data_out        (obs.wdata),
        .wb_error              (wb_error)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retired_count         (retired_count)
`endif
    );

    always #5 clock1 = ~clock1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // What the stage must do this cycle, from the current inputs and pending pair half.
    task automatic predict(output bit v, output wb_write_t w, output bit st, output bit err);
        v = 1'b0; w = '0; st = 1'b0; err = 1'b0;
        if (reset_n !== 1'b1) return;
        if (m_pending.size() != 0) begin
            v = 1'b1;
            w = m_pending[0];
        end else begin
            case (code)
                2'd1: begin v = 1'b1; w.addr = dest; w.data = alu1; end
                2'd2: begin
                    if (mem_rd) begin v = 1'b1; w.addr = dest; w.data = mem_out; end
                    else err = 1'b1;
                end
                2'd3: begin v = 1'b1; st = 1'b1; w.addr = dest; w.data = alu1; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit v, input wb_write_t w);
        if (a == 5'd0) return 32'd0;
        if (v && (w.addr == a)) return w.data;
        return m_regs[a];
    endfunction

    always @(posedge clock1 or negedge reset_n) begin : model_update
        bit        v, st, err, popped, retire;
        wb_write_t w, nxt;
        if (!reset_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_pending.delete();
            m_error   = 1'b0;
            m_retired = '0;
        end else begin
            predict(v, w, st, err);
            popped = (m_pending.size() != 0);
            if (popped) void'(m_pending.pop_front());
            retire = popped || (code == 2'd1) || ((code == 2'd2) && mem_rd);
            if (v && (w.addr != 5'd0)) m_regs[w.addr] = w.data;
            if (err) m_error = 1'b1;
            if (retire) m_retired = m_retired + 32'd1;
            if (st) begin
                nxt.addr = 5'((int'(dest) + 1) % 32);
                nxt.data = alu2;
                m_pending.push_back(nxt);
            end
        end
    end

    always @(negedge clock1) begin : compare
        bit        v, st, err;
        wb_write_t w;
        predict(v, w, st, err);
        check("cmp_stall", 32'(stall), 32'(st));
        check("cmp_we", 32'(obs.we), 32'(v && (w.addr != 5'd0)));
        if (v && (w.addr != 5'd0)) begin
            check("cmp_waddr", 32'(obs.waddr), 32'(w.addr));
            check("cmp_wdata", obs.wdata, w.data);
        end
        check("cmp_rd_a", obs.rdata_a, exp_read(obs.raddr_a, v, w));
        check("cmp_rd_b", obs.rdata_b, exp_read(obs.raddr_b, v, w));
        check("cmp_error", 32'(wb_error), 32'(m_error));
`ifdef WB_RETIRE_COUNT_EN
        check("cmp_retired", retired_count, m_retired);
`endif
    end

    task automatic drive(input logic [1:0] c, input logic mr, input logic [4:0] d,
                         input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] mo);
        code = c; mem_rd = mr; dest = d; alu1 = a1; alu2 = a2; mem_out = mo;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clock1);
        #1;
    endtask

    task automatic settle();
        @(negedge clock1);
        #1;
    endtask

    initial begin
        logic [4:0] rd;
        reset_n = 1'b0;
        idle();
        obs.raddr_a = 5'd0;
        obs.raddr_b = 5'd0;
        tick();
        tick();

        // A pair presented while reset is held must neither stall nor write.
        drive(2'd3, 1'b0, 5'd7, 32'h2, 32'h1, 32'h0);
        obs.raddr_a = 5'd7;
        settle();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_we", 32'(obs.we), 32'd0);
        check("rst_rd7", obs.rdata_a, 32'd0);
        check("rst_error", 32'(wb_error), 32'd0);
        tick();
        idle();
        reset_n = 1'b1;

        // ALU write on the first edge after reset release.
        drive(2'd1, 1'b0, 5'd2, 32'h15, 32'h0, 32'h0);
        tick();
        idle();
        obs.raddr_a = 5'd2;
        settle();
        check("alu_r2", obs.rdata_a, 32'h15);
        check("model_r2", m_regs[2], 32'h15);
`ifdef WB_RETIRE_COUNT_EN
        check("alu_retired", retired_count, 32'd1);
`endif
        tick();

        // Load: bypass in the same cycle, then from the file.
        drive(2'd2, 1'b1, 5'd5, 32'h0, 32'h0, 32'h8);
        obs.raddr_b = 5'd5;
        settle();
        check("mem_bypass_r5", obs.rdata_b, 32'h8);
        check("mem_we", 32'(obs.we), 32'd1);
        check("mem_waddr", 32'(obs.waddr), 32'd5);
        tick();
        idle();
        settle();
        check("mem_r5", obs.rdata_b, 32'h8);
        tick();

        // Pair: one stall cycle, second half ignores inputs.
        drive(2'd3, 1'b0, 5'd7, 32'h2, 32'h1, 32'h0);
        obs.raddr_a = 5'd7;
        obs.raddr_b = 5'd8;
        settle();
        check("pair_stall1", 32'(stall), 32'd1);
        check("pair_bypass_r7", obs.rdata_a, 32'h2);
        check("pair_r8_before", obs.rdata_b, 32'h0);
        tick();
        drive(2'd1, 1'b0, 5'd8, 32'hDEAD, 32'hBEEF, 32'h0);
        settle();
        check("pair_stall2", 32'(stall), 32'd0);
        check("pair_waddr2", 32'(obs.waddr), 32'd8);
        check("pair_wdata2", obs.wdata, 32'h1);
        check("pair_r7", obs.rdata_a, 32'h2);
        tick();
        idle();
        settle();
        check("pair_stall3", 32'(stall), 32'd0);
        check("pair_r8", obs.rdata_b, 32'h1);
        check("model_r8", m_regs[8], 32'h1);
`ifdef WB_RETIRE_COUNT_EN
        check("pair_retired", retired_count, 32'd3);
`endif
        tick();

        // Register 0 is never written, including by a wrapping pair.
        drive(2'd1, 1'b0, 5'd0, 32'h15, 32'h0, 32'h0);
        obs.raddr_a = 5'd0;
        settle();
        check("r0_we", 32'(obs.we), 32'd0);
        check("r0_bypass", obs.rdata_a, 32'd0);
        tick();
        drive(2'd3, 1'b0, 5'd31, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0);
        obs.raddr_a = 5'd31;
        obs.raddr_b = 5'd0;
        settle();
        check("wrap_stall", 32'(stall), 32'd1);
        tick();
        idle();
        settle();
        check("wrap_we2", 32'(obs.we), 32'd0);
        check("wrap_r0_pair2", obs.rdata_b, 32'd0);
        tick();
        settle();
        check("wrap_r31", obs.rdata_a, 32'hAAAA_0001);
        check("wrap_r0", obs.rdata_b, 32'd0);
        tick();

        // Store-coded-as-memory with no load: no write, sticky error.
        drive(2'd2, 1'b0, 5'd5, 32'h0, 32'h0, 32'h77);
        obs.raddr_a = 5'd5;
        settle();
        check("err_we", 32'(obs.we), 32'd0);
        check("err_r5_same", obs.rdata_a, 32'h8);
        check("err_flag_pre", 32'(wb_error), 32'd0);
        tick();
        drive(2'd1, 1'b0, 5'd4, 32'h44, 32'h0, 32'h0);
        settle();
        check("err_flag", 32'(wb_error), 32'd1);
        check("err_r5_kept", obs.rdata_a, 32'h8);
        tick();
        idle();
        settle();
        check("err_sticky", 32'(wb_error), 32'd1);
        check("model_error", 32'(m_error), 32'd1);
        tick();

        // Randomized traffic with one asynchronous reset pulse in the middle.
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) reset_n = 1'b0;
            if (n == 1003) reset_n = 1'b1;
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
            case ($urandom_range(0, 3))
                0, 1: rd = dest;
                2:    rd = dest + 5'd1;
                default: rd = 5'($urandom_range(0, 31));
            endcase
            obs.raddr_a = rd;
            obs.raddr_b = 5'($urandom_range(0, 31));
            tick();
        end

        // Reset pulse while the second pair half is pending.
        idle();
        tick();
        tick();
        drive(2'd3, 1'b0, 5'd10, 32'h11, 32'h22, 32'h0);
        obs.raddr_a = 5'd10;
        obs.raddr_b = 5'd11;
        tick();
        reset_n = 1'b0;
        idle();
        settle();
        check("rst2_stall", 32'(stall), 32'd0);
        check("rst2_we", 32'(obs.we), 32'd0);
        check("rst2_r10", obs.rdata_a, 32'd0);
        check("rst2_r11", obs.rdata_b, 32'd0);
        check("rst2_error", 32'(wb_error), 32'd0);
        check("model_pending", 32'(m_pending.size()), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        settle();
        check("rst2_r11_after", obs.rdata_b, 32'd0);
`ifdef WB_RETIRE_COUNT_EN
        check("rst2_retired", retired_count, 32'd0);
`endif
        tick();
        for (int i = 0; i < 32; i++) begin
            obs.raddr_a = 5'(i);
            obs.raddr_b = 5'(31 - i);
            settle();
            check("rst2_scan", obs.rdata_a, 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
